jk_excite_ctrl: RTL and testbench

//  Closed-loop driver for a bank of W external JK flip-flops that share CLK.

---
 rtl/jk_excite_ctrl_pkg.sv | 16 +
 rtl/jk_excite_ctrl_bit.sv | 20 ++
 rtl/jk_excite_ctrl.sv | 143 ++++++++++++++
 tb/tb_jk_excite_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_excite_ctrl_pkg.sv
// rtl/jk_excite_ctrl_pkg.sv - state encodings and op codes for the JK excitation driver
package jk_excite_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_UP   = 2'd1;
    localparam logic [1:0] OP_DOWN = 2'd2;

endpackage

// File: rtl/jk_excite_ctrl_bit.sv
// rtl/jk_excite_ctrl_bit.sv - JK excitation for one flip-flop (current q -> target)
module jk_excite_ctrl_bit #(
    parameter int DC_MODE = 0
) (
    input  logic q_i,
    input  logic tgt_i,
    output logic j_o,
    output logic k_o
);

    // Toggle form fills both don't-cares with the change bit; exact form leaves them 0.
    if (DC_MODE == 1) begin : g_toggle
        assign j_o = tgt_i ^ q_i;
        assign k_o = tgt_i ^ q_i;
    end else begin : g_exact
        assign j_o = tgt_i & ~q_i;
        assign k_o = ~tgt_i & q_i;
    end

endmodule

// File: rtl/jk_excite_ctrl.sv
// rtl/jk_excite_ctrl.sv - closed-loop J/K driver with readback verify for a bank of JK flip-flops
module jk_excite_ctrl
    import jk_excite_ctrl_pkg::*;
#(
    parameter int W       = 4,
    parameter int DC_MODE = 0
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_arg,
    input  logic [W-1:0] q_in,
    input  logic [W-1:0] qn_in,
    output logic [W-1:0] j_o,
    output logic [W-1:0] k_o,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] err_bits,
    input  logic         err_clr
);

    state_e       state_q, state_d;
    logic [W-1:0] j_q, j_d, k_q, k_d;
    logic [W-1:0] exp_q, exp_d;
    logic [W-1:0] steps_q, steps_d;
    logic [1:0]   op_q, op_d;
    logic         err_q, err_d;
    logic [W-1:0] err_bits_q, err_bits_d;

    logic [1:0]   op_sel;
    logic [W-1:0] tgt, jn, kn, fault;
    logic         is_count;

    // In VERIFY the next count target comes from the latched op, never the live inputs.
    assign op_sel   = (state_q == ST_IDLE) ? cmd_op : op_q;
    assign is_count = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);

    always_comb begin
        case (op_sel)
            OP_UP:   tgt = q_in + W'(1);
            OP_DOWN: tgt = q_in - W'(1);
            default: tgt = cmd_arg;
        endcase
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        jk_excite_ctrl_bit #(.DC_MODE(DC_MODE)) u_bit (
            .q_i   (q_in[i]),
            .tgt_i (tgt[i]),
            .j_o   (jn[i]),
            .k_o   (kn[i])
        );
    end

    // A bit is bad if it missed its target or its complementary outputs agree.
    assign fault = (q_in ^ exp_q) | ~(q_in ^ qn_in);

    always_comb begin
        state_d    = state_q;
        j_d        = '0;
        k_d        = '0;
        exp_d      = exp_q;
        steps_d    = steps_q;
        op_d       = op_q;
        err_d      = err_q;
        err_bits_d = err_bits_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    steps_d = is_count ? cmd_arg : W'(1);
                    if (is_count && (cmd_arg == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        j_d     = jn;
                        k_d     = kn;
                        exp_d   = tgt;
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_APPLY: state_d = ST_VERIFY;
            ST_VERIFY: begin
                if (|fault) begin
                    err_d      = 1'b1;
                    err_bits_d = fault;
                    state_d    = ST_ERROR;
                end else if (steps_q > W'(1)) begin
                    steps_d = steps_q - W'(1);
                    j_d     = jn;
                    k_d     = kn;
                    exp_d   = tgt;
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERROR: begin
                if (err_clr) begin
                    err_d      = 1'b0;
                    err_bits_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= ST_IDLE;
            j_q        <= '0;
            k_q        <= '0;
            exp_q      <= '0;
            steps_q    <= '0;
            op_q       <= OP_LOAD;
            err_q      <= 1'b0;
            err_bits_q <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            exp_q      <= exp_d;
            steps_q    <= steps_d;
            op_q       <= op_d;
            err_q      <= err_d;
            err_bits_q <= err_bits_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_APPLY) || (state_q == ST_VERIFY);
    assign done      = (state_q == ST_DONE);
    assign j_o       = j_q;
    assign k_o       = k_q;
    assign err       = err_q;
    assign err_bits  = err_bits_q;

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// tb/tb_jk_excite_ctrl.sv - bench: two drivers (exact and toggle fill) each closing the loop on a JK bank model
module tb_jk_excite_ctrl;

    localparam logic [1:0] LD = 2'd0, UP = 2'd1, DN = 2'd2, RSV = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    logic       cv0, cv1, ec0, ec1, rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
    logic [1:0] op0, op1;
    logic [3:0] arg0, arg1, j0, j1, k0, k1, eb0, eb1;
    logic [3:0] bq0, bq1, qn0, qn1, stuck0, stuck1, qeq0, qeq1;

    jk_excite_ctrl #(.W(4), .DC_MODE(0)) u_dut0 (
        .CLK(clk), .RST_n(rst_n), .cmd_valid(cv0), .cmd_ready(rdy0), .cmd_op(op0),
        .cmd_arg(arg0), .q_in(bq0), .qn_in(qn0), .j_o(j0), .k_o(k0), .busy(busy0),
        .done(done0), .err(err0), .err_bits(eb0), .err_clr(ec0)
    );

    jk_excite_ctrl #(.W(4), .DC_MODE(1)) u_dut1 (
        .CLK(clk), .RST_n(rst_n), .cmd_valid(cv1), .cmd_ready(rdy1), .cmd_op(op1),
        .cmd_arg(arg1), .q_in(bq1), .qn_in(qn1), .j_o(j1), .k_o(k1), .busy(busy1),
        .done(done1), .err(err1), .err_bits(eb1), .err_clr(ec1)
    );

    // JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits and qn forced equal to q.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bq0 <= 4'b0000;
            bq1 <= 4'b0000;
        end else begin
            bq0 <= ((j0 & ~bq0) | (~k0 & bq0)) & ~stuck0;
            bq1 <= ((j1 & ~bq1) | (~k1 & bq1)) & ~stuck1;
        end
    end
    assign qn0 = ~bq0 ^ qeq0;
    assign qn1 = ~bq1 ^ qeq1;

    int errors = 0;
    int checks = 0;
    logic [3:0] mq [2];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gj(int m);   return (m == 0) ? j0 : j1;       endfunction
    function automatic logic [3:0] gk(int m);   return (m == 0) ? k0 : k1;       endfunction
    function automatic logic [3:0] gq(int m);   return (m == 0) ? bq0 : bq1;     endfunction
    function automatic logic [3:0] geb(int m);  return (m == 0) ? eb0 : eb1;     endfunction
    function automatic logic gb(int m);         return (m == 0) ? busy0 : busy1; endfunction
    function automatic logic gd(int m);         return (m == 0) ? done0 : done1; endfunction
    function automatic logic grdy(int m);       return (m == 0) ? rdy0 : rdy1;   endfunction
    function automatic logic gerr(int m);       return (m == 0) ? err0 : err1;   endfunction

    task automatic drive(int m, logic v, logic [1:0] o, logic [3:0] a, logic c);
        if (m == 0) begin
            cv0 = v; op0 = o; arg0 = a; ec0 = c;
        end else begin
            cv1 = v; op1 = o; arg1 = a; ec1 = c;
        end
    endtask

    // Reference J/K from the excitation table: instance 0 uses exact fill, instance 1 toggle fill.
    function automatic logic [7:0] jk_model(int m, logic [3:0] q, logic [3:0] t);
        logic [3:0] jv, kv;
        for (int b = 0; b < 4; b++) begin
            if (m == 1) begin
                jv[b] = (q[b] != t[b]);
                kv[b] = (q[b] != t[b]);
            end else begin
                jv[b] = (q[b] == 1'b0) && (t[b] == 1'b1);
                kv[b] = (q[b] == 1'b1) && (t[b] == 1'b0);
            end
        end
        return {jv, kv};
    endfunction

    task automatic do_cmd(int m, logic [1:0] op, logic [3:0] arg);
        int steps;
        logic [3:0] t, qc;
        logic [7:0] jk;
        steps = (op == UP || op == DN) ? int'(arg) : 1;
        qc = mq[m];
        @(negedge clk);
        chk("ready_idle", grdy(m), 1);
        drive(m, 1'b1, op, arg, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(m, 1'b0, 2'($urandom), 4'($urandom), 1'b0);
        for (int s = 0; s < steps; s++) begin
            t = (op == UP) ? 4'((qc + 1) % 16) : (op == DN) ? 4'((qc + 15) % 16) : arg;
            jk = jk_model(m, qc, t);
            chk("apply_j", gj(m), jk[7:4]);
            chk("apply_k", gk(m), jk[3:0]);
            chk("apply_busy", gb(m), 1);
            @(posedge clk);
            @(negedge clk);
            chk("verify_q", gq(m), t);
            chk("verify_jk", {gj(m), gk(m)}, 0);
            chk("verify_done", gd(m), 0);
            qc = t;
            @(posedge clk);
            @(negedge clk);
        end
        chk("done_pulse", gd(m), 1);
        chk("done_jk", {gj(m), gk(m)}, 0);
        chk("done_busy", gb(m), 0);
        @(posedge clk);
        @(negedge clk);
        chk("done_clear", gd(m), 0);
        chk("ready_after", grdy(m), 1);
        chk("no_err", gerr(m), 0);
        mq[m] = qc;
    endtask

    typedef struct {
        int         m;
        logic [1:0] op;
        logic [3:0] arg;
        logic [3:0] fq;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{0, LD,  4'b1010, 4'b1010};
        vt[1]  = '{0, LD,  4'b1110, 4'b1110};
        vt[2]  = '{0, UP,  4'd3,    4'b0001};
        vt[3]  = '{1, DN,  4'd1,    4'b1111};
        vt[4]  = '{1, UP,  4'd0,    4'b1111};
        vt[5]  = '{0, RSV, 4'b0110, 4'b0110};
        vt[6]  = '{1, DN,  4'd2,    4'b1101};
        vt[7]  = '{0, UP,  4'd15,   4'b0101};
        vt[8]  = '{1, LD,  4'b0011, 4'b0011};
        vt[9]  = '{0, DN,  4'd0,    4'b0101};
        vt[10] = '{0, DN,  4'd6,    4'b1111};
        vt[11] = '{1, UP,  4'd13,   4'b0000};

        rst_n = 1'b0;
        drive(0, 1'b0, LD, 4'd0, 1'b0);
        drive(1, 1'b0, LD, 4'd0, 1'b0);
        stuck0 = '0; stuck1 = '0; qeq0 = '0; qeq1 = '0;
        mq[0] = '0; mq[1] = '0;
        #12;
        chk("rst_jk", {j0, k0, j1, k1}, 0);
        chk("rst_ready", {rdy0, rdy1}, 2'b11);
        chk("rst_err", {err0, err1, eb0, eb1}, 0);
        chk("rst_busy_done", {busy0, busy1, done0, done1}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            do_cmd(vt[i].m, vt[i].op, vt[i].arg);
            chk("vec_final_q", gq(vt[i].m), vt[i].fq);
        end

        repeat (20) begin
            do_cmd(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom));
        end

        // Stuck bit 2 on bank 0: LOAD 0100 must fault on that bit only.
        do_cmd(0, LD, 4'b0000);
        stuck0 = 4'b0100;
        @(negedge clk);
        drive(0, 1'b1, LD, 4'b0100, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, LD, 4'b0000, 1'b0);
        chk("flt_apply_jk", {j0, k0}, {4'b0100, 4'b0000});
        @(posedge clk);
        @(negedge clk);
        chk("flt_verify", {err0, busy0}, 2'b01);
        @(posedge clk);
        @(negedge clk);
        chk("flt_err", err0, 1);
        chk("flt_bits", eb0, 4'b0100);
        chk("flt_state", {rdy0, busy0, done0, j0, k0}, 0);
        drive(0, 1'b1, LD, 4'b1111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("flt_sticky", {err0, eb0, rdy0, j0, k0}, {1'b1, 4'b0100, 1'b0, 8'h00});
        drive(0, 1'b0, LD, 4'b0000, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, LD, 4'b0000, 1'b0);
        chk("flt_clr", {err0, eb0, rdy0, done0}, {1'b0, 4'b0000, 1'b1, 1'b0});
        stuck0 = '0;
        mq[0] = 4'b0000;

        // qn equal to q on bit 0 of bank 1 is a fault even when q reaches its target.
        qeq1 = 4'b0001;
        @(negedge clk);
        drive(1, 1'b1, LD, ~mq[1], 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, LD, 4'b0000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("qn_err", {err1, eb1, rdy1}, {1'b1, 4'b0001, 1'b0});
        drive(1, 1'b0, LD, 4'b0000, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, LD, 4'b0000, 1'b0);
        chk("qn_clr", {err1, eb1, rdy1}, {1'b0, 4'b0000, 1'b1});
        qeq1 = '0;
        mq[1] = gq(1);
        do_cmd(1, UP, 4'd2);

        // Reset during APPLY of COUNT_UP 5: J/K drop at once, no done pulse follows.
        @(negedge clk);
        drive(0, 1'b1, UP, 4'd5, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, LD, 4'd0, 1'b0);
        chk("rst_apply_jk", {j0, k0}, jk_model(0, mq[0], 4'((mq[0] + 1) % 16)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_jk", {j0, k0}, 0);
        chk("rst_async_busy", {busy0, done0, rdy0}, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        mq[0] = '0; mq[1] = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("rst_no_done", {done0, busy0, rdy0, err0}, 4'b0010);
        end
        do_cmd(0, UP, 4'd1);
        chk("post_rst_q", bq0, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
